// File: rtl/dds_increment_ramp_if.sv
// Control/status bundle for the DDS increment slewer.
// The controller side is master and the slewer is slave.
interface dds_increment_ramp_if #(
  parameter int WIDTH    = 32,
  parameter int STEP_W   = 16,
  parameter int PERIOD_W = 16
);
  logic                enable;
  logic [WIDTH-1:0]    target_increment;
  logic [STEP_W-1:0]   max_step;
  logic [PERIOD_W-1:0] update_period;
  logic [WIDTH-1:0]    increment_out;
  logic                update_strobe;
  logic                busy;
  logic                at_target;

  modport master (
    output enable, target_increment, max_step, update_period,
    input  increment_out, update_strobe, busy, at_target
  );

  modport slave (
    input  enable, target_increment, max_step, update_period,
    output increment_out, update_strobe, busy, at_target
  );
endinterface

// File: rtl/dds_increment_ramp.sv
// Rate-limited slewer that walks the DDS phase increment toward a target.
// Steps are bounded, so the clock chain downstream stays locked while retuning.
module dds_increment_ramp #(
  parameter int               WIDTH             = 32,
  parameter logic [WIDTH-1:0] DEFAULT_INCREMENT = 32'h33333333,
  parameter int               STEP_W            = 16,
  parameter int               PERIOD_W          = 16
) (
  input  logic clk_ref,
  input  logic clk_ref_aresetn,
  dds_increment_ramp_if.slave bus
);

  typedef enum logic {IDLE, RAMP} state_t;

  localparam logic [PERIOD_W-1:0] PRE_ONE = 1;

  state_t              state;
  logic [WIDTH-1:0]    target_q;
  logic [WIDTH-1:0]    inc_q;
  logic [PERIOD_W-1:0] prescaler;
  logic                strobe_q;
  logic                at_target_q;

  logic             up;
  logic [WIDTH:0]   diff;
  logic [WIDTH:0]   step_ext;
  logic [WIDTH-1:0] nxt;

  // The step is only taken when diff > max_step, so the result can neither
  // overshoot the target nor wrap past either end of the range.
  always_comb begin
    up       = target_q > inc_q;
    diff     = up ? ({1'b0, target_q} - {1'b0, inc_q})
                  : ({1'b0, inc_q} - {1'b0, target_q});
    step_ext = {{(WIDTH+1-STEP_W){1'b0}}, bus.max_step};
    nxt      = target_q;
    if (bus.max_step != '0 && diff > step_ext)
      nxt = up ? inc_q + step_ext[WIDTH-1:0] : inc_q - step_ext[WIDTH-1:0];
  end

  always_ff @(posedge clk_ref or negedge clk_ref_aresetn) begin
    if (!clk_ref_aresetn) begin
      state       <= IDLE;
      target_q    <= DEFAULT_INCREMENT;
      inc_q       <= DEFAULT_INCREMENT;
      prescaler   <= '0;
      strobe_q    <= 1'b0;
      at_target_q <= 1'b1;
    end else begin
      target_q    <= bus.target_increment;
      at_target_q <= (inc_q == target_q);
      strobe_q    <= 1'b0;
      case (state)
        IDLE: begin
          prescaler <= '0;
          if (bus.enable && inc_q != target_q) state <= RAMP;
        end
        RAMP: begin
          if (!bus.enable) begin
            state     <= IDLE;
            prescaler <= '0;
          end else if (prescaler != bus.update_period) begin
            prescaler <= prescaler + PRE_ONE;
          end else begin
            prescaler <= '0;
            inc_q     <= nxt;
            // A target moved back onto the output finishes silently.
            strobe_q  <= (nxt != inc_q);
            if (nxt == target_q) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.increment_out = inc_q;
  assign bus.update_strobe = strobe_q;
  assign bus.busy          = (state == RAMP);
  assign bus.at_target     = at_target_q;

endmodule

// File: tb/tb_dds_increment_ramp.sv
// Directed bench for dds_increment_ramp with hand-computed expected values.
module tb_dds_increment_ramp;
  logic clk_ref = 1'b0;
  logic clk_ref_aresetn;
  int   checks = 0;
  int   failures = 0;
  int   strobe_cnt = 0;
  int   n;
  int   s0;

  dds_increment_ramp_if #(.WIDTH(32), .STEP_W(16), .PERIOD_W(16)) bus ();

  dds_increment_ramp #(
    .WIDTH(32), .DEFAULT_INCREMENT(32'h33333333), .STEP_W(16), .PERIOD_W(16)
  ) dut (
    .clk_ref(clk_ref),
    .clk_ref_aresetn(clk_ref_aresetn),
    .bus(bus)
  );

  always #5 clk_ref = ~clk_ref;

  always @(negedge clk_ref)
    if (bus.update_strobe === 1'b1) strobe_cnt <= strobe_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int k);
    repeat (k) @(negedge clk_ref);
    #1;
  endtask

  // Cycles (negedges) until the next strobe, bounded.
  task automatic wait_upd(output int cyc);
    cyc = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk_ref);
      cyc++;
      if (bus.update_strobe === 1'b1) break;
    end
    #1;
    if (bus.update_strobe !== 1'b1) chk("strobe_timeout", 32'd0, 32'd1);
  endtask

  task automatic drive(input logic [31:0] tgt, input logic [15:0] stp, input logic [15:0] per);
    bus.target_increment = tgt;
    bus.max_step         = stp;
    bus.update_period    = per;
  endtask

  initial begin
    clk_ref_aresetn      = 1'b0;
    bus.enable           = 1'b1;
    drive(32'h33333333, 16'h0040, 16'd3);
    #22;
    chk("rst_inc", bus.increment_out, 32'h33333333);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_at_target", {31'd0, bus.at_target}, 32'd1);
    clk_ref_aresetn = 1'b1;

    // 1: idle after reset, nothing moves
    step(10);
    chk("t1_inc", bus.increment_out, 32'h33333333);
    chk("t1_busy", {31'd0, bus.busy}, 32'd0);
    chk("t1_at_target", {31'd0, bus.at_target}, 32'd1);
    chk("t1_strobes", strobe_cnt, 32'd0);

    // 2: upward ramp, period 3 -> updates 4 cycles apart
    s0 = strobe_cnt;
    drive(32'h33333433, 16'h0040, 16'd3);
    wait_upd(n);
    chk("t2_lat", n, 32'd6);
    chk("t2_v1", bus.increment_out, 32'h33333373);
    chk("t2_busy", {31'd0, bus.busy}, 32'd1);
    wait_upd(n);
    chk("t2_gap2", n, 32'd4);
    chk("t2_v2", bus.increment_out, 32'h333333B3);
    wait_upd(n);
    chk("t2_gap3", n, 32'd4);
    chk("t2_v3", bus.increment_out, 32'h333333F3);
    wait_upd(n);
    chk("t2_gap4", n, 32'd4);
    chk("t2_v4", bus.increment_out, 32'h33333433);
    chk("t2_busy_done", {31'd0, bus.busy}, 32'd0);
    step(3);
    chk("t2_at_target", {31'd0, bus.at_target}, 32'd1);
    chk("t2_strobes", strobe_cnt - s0, 32'd4);
    chk("t2_hold", bus.increment_out, 32'h33333433);

    // 3: downward with partial final step, period 0
    drive(32'h333333F0, 16'h0040, 16'd0);
    wait_upd(n);
    chk("t3_lat", n, 32'd3);
    chk("t3_v1", bus.increment_out, 32'h333333F3);
    wait_upd(n);
    chk("t3_gap", n, 32'd1);
    chk("t3_v2", bus.increment_out, 32'h333333F0);
    step(3);
    chk("t3_busy", {31'd0, bus.busy}, 32'd0);
    chk("t3_hold", bus.increment_out, 32'h333333F0);

    // back to default by an unlimited jump
    drive(32'h33333333, 16'h0000, 16'd0);
    wait_upd(n);
    chk("t4_jump", bus.increment_out, 32'h33333333);
    step(3);

    // 4: direction reversal after the second update
    drive(32'h33333433, 16'h0040, 16'd3);
    wait_upd(n);
    chk("t4_v1", bus.increment_out, 32'h33333373);
    wait_upd(n);
    chk("t4_v2", bus.increment_out, 32'h333333B3);
    bus.target_increment = 32'h33333300;
    wait_upd(n);
    chk("t4_rev_gap", n, 32'd4);
    chk("t4_rev_v", bus.increment_out, 32'h33333373);
    wait_upd(n);
    chk("t4_v4", bus.increment_out, 32'h33333333);
    wait_upd(n);
    chk("t4_v5", bus.increment_out, 32'h33333300);
    step(2);
    chk("t4_busy", {31'd0, bus.busy}, 32'd0);

    // 5: freeze mid-ramp, then unlimited step
    drive(32'h33333433, 16'h0040, 16'd3);
    wait_upd(n);
    chk("t5_v1", bus.increment_out, 32'h33333340);
    bus.enable = 1'b0;
    s0 = strobe_cnt;
    step(6);
    chk("t5_freeze", bus.increment_out, 32'h33333340);
    chk("t5_busy", {31'd0, bus.busy}, 32'd0);
    chk("t5_at_target", {31'd0, bus.at_target}, 32'd0);
    chk("t5_no_strobe", strobe_cnt - s0, 32'd0);
    bus.max_step = 16'h0000;
    bus.enable   = 1'b1;
    wait_upd(n);
    chk("t5_lat", n, 32'd5);
    chk("t5_jump", bus.increment_out, 32'h33333433);
    step(4);
    chk("t5_single", strobe_cnt - s0, 32'd1);

    // target moved back onto the output while idle: no action
    s0 = strobe_cnt;
    drive(32'h33333433, 16'h0040, 16'd0);
    step(5);
    chk("t5_idle_nop", strobe_cnt - s0, 32'd0);

    // 6: extremes, one step to the top, no wrap
    drive(32'hFFFF0000, 16'h0000, 16'd0);
    wait_upd(n);
    chk("t6_base", bus.increment_out, 32'hFFFF0000);
    step(2);
    s0 = strobe_cnt;
    drive(32'hFFFFFFFF, 16'hFFFF, 16'd0);
    wait_upd(n);
    chk("t6_top", bus.increment_out, 32'hFFFFFFFF);
    step(4);
    chk("t6_one_step", strobe_cnt - s0, 32'd1);
    chk("t6_busy", {31'd0, bus.busy}, 32'd0);

    // downward from the top, then asynchronous reset mid-ramp
    drive(32'h00000000, 16'h1000, 16'd3);
    wait_upd(n);
    chk("t6_down", bus.increment_out, 32'hFFFFEFFF);
    #2;
    clk_ref_aresetn = 1'b0;
    #1;
    chk("t6_async_inc", bus.increment_out, 32'h33333333);
    chk("t6_async_busy", {31'd0, bus.busy}, 32'd0);
    chk("t6_async_strobe", {31'd0, bus.update_strobe}, 32'd0);
    bus.target_increment = 32'h33333333;
    step(2);
    clk_ref_aresetn = 1'b1;
    step(4);
    chk("t6_post_rst", bus.increment_out, 32'h33333333);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
